// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Define BCD_VALID_CHECK_EN to reject digits > 9 with o_err and an early o_done.
module bcd_to_bin_seq #(
  parameter int unsigned N_DIGITS = 2,
  parameter int unsigned BIN_W    = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [4*N_DIGITS-1:0]   i_bcd,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BIN_W-1:0]        o_bin,
  output logic                    o_err
);

  localparam int unsigned BCD_W  = 4 * N_DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d, shifted;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                busy_d, done_d, out_err_d;
  logic [BIN_W-1:0]    bin_d;
  logic                bad_digit;

  // One reverse double-dabble step: shift right, then correct each digit >= 8
  always_comb begin
    shifted = work_q >> 1;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (shifted[BIN_W + 4*k + 3])
        shifted[BIN_W + 4*k +: 4] = shifted[BIN_W + 4*k +: 4] - 4'd3;
    end
  end

`ifdef BCD_VALID_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (work_q[BIN_W + 4*k +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bin_d     = o_bin;
    out_err_d = o_err;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          work_d  = {i_bcd, BIN_W'(0)};
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bad_digit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        bin_d     = err_q ? '0 : work_q[BIN_W-1:0];
        out_err_d = err_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_bin   <= '0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_bin   <= bin_d;
      o_err   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: 2-digit (BIN_W=7) and 3-digit (BIN_W=10) instances.
// Expectations for 8'h3A follow BCD_VALID_CHECK_EN.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst, start, sel;
  logic [11:0] bcd_in;

  logic        busy2, done2, err2;
  logic [6:0]  bin2;
  logic        busy3, done3, err3;
  logic [9:0]  bin3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.N_DIGITS(2), .BIN_W(7)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .i_bcd(bcd_in[7:0]),
    .o_busy(busy2), .o_done(done2), .o_bin(bin2), .o_err(err2)
  );

  bcd_to_bin_seq #(.N_DIGITS(3), .BIN_W(10)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start & sel), .i_bcd(bcd_in),
    .o_busy(busy3), .o_done(done3), .o_bin(bin3), .o_err(err3)
  );

  logic    busy_m, done_m, err_m;
  longint  bin_m, res_m;
  assign busy_m = sel ? busy3 : busy2;
  assign done_m = sel ? done3 : done2;
  assign err_m  = sel ? err3  : err2;
  assign bin_m  = sel ? longint'(bin3) : longint'(bin2);
  assign res_m  = sel ? longint'(dut3.work_q[21:10]) : longint'(dut2.work_q[14:7]);

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge 0).
  task automatic convert(input bit use3, input logic [11:0] bcd, input longint exp_bin,
                         input bit exp_err, input int exp_lat, input int poke_at,
                         input logic [11:0] poke_bcd, input int extra);
    int lat, busy_n, extra_done;
    lat = -1; busy_n = 0; extra_done = 0;
    sel = use3; start = 1'b1; bcd_in = bcd;
    @(negedge clk);
    bcd_in = ~bcd;
    for (int e = 0; e < 40; e++) begin
      if (e == poke_at) begin
        start = 1'b1; bcd_in = poke_bcd;
      end else begin
        start = 1'b0;
      end
      if (done_m) begin
        lat = e;
        break;
      end
      if (busy_m) busy_n++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq($sformatf("latency_%h", bcd), lat, exp_lat);
    check_eq($sformatf("bin_%h", bcd), bin_m, exp_bin);
    check_eq($sformatf("err_%h", bcd), longint'(err_m), longint'(exp_err));
    check_eq($sformatf("busy_cycles_%h", bcd), busy_n, exp_lat - 1);
    if (!exp_err) check_eq($sformatf("residual_%h", bcd), res_m, 0);
    if (extra > 0) begin
      for (int i = 0; i < extra; i++) begin
        @(negedge clk);
        if (done_m) extra_done++;
      end
      check_eq($sformatf("extra_done_%h", bcd), extra_done, 0);
    end
  endtask

  initial begin
    int stray;
    rst = 1'b1; start = 1'b1; sel = 1'b0; bcd_in = 12'h099;
    repeat (3) @(negedge clk);
    check_eq("rst_busy2", longint'(busy2), 0);
    check_eq("rst_done2", longint'(done2), 0);
    check_eq("rst_bin2", longint'(bin2), 0);
    check_eq("rst_err2", longint'(err2), 0);
    check_eq("rst_busy3", longint'(busy3), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", longint'(busy2), 0);

    convert(1'b0, 12'h000, 0, 1'b0, 9, -1, 12'h0, 0);
    convert(1'b0, 12'h099, 99, 1'b0, 9, -1, 12'h0, 0);
    convert(1'b0, 12'h047, 47, 1'b0, 9, -1, 12'h0, 0);
    convert(1'b0, 12'h009, 9, 1'b0, 9, -1, 12'h0, 0);
    convert(1'b0, 12'h090, 90, 1'b0, 9, -1, 12'h0, 0);
`ifdef BCD_VALID_CHECK_EN
    convert(1'b0, 12'h03A, 0, 1'b1, 2, -1, 12'h0, 0);
`else
    convert(1'b0, 12'h03A, 40, 1'b0, 9, -1, 12'h0, 0);
`endif
    convert(1'b0, 12'h025, 25, 1'b0, 9, 3, 12'h077, 12);

    // Reset while converting 8'h55: abort, clear outputs, no o_done
    sel = 1'b0; start = 1'b1; bcd_in = 12'h055;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", longint'(busy2), 0);
    check_eq("abort_done", longint'(done2), 0);
    check_eq("abort_bin", longint'(bin2), 0);
    check_eq("abort_err", longint'(err2), 0);
    stray = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done2) stray++;
    end
    check_eq("abort_no_done", stray, 0);
    convert(1'b0, 12'h012, 12, 1'b0, 9, -1, 12'h0, 0);

    convert(1'b1, 12'h999, 999, 1'b0, 12, -1, 12'h0, 0);
    convert(1'b1, 12'h100, 100, 1'b0, 12, -1, 12'h0, 0);
    convert(1'b1, 12'h305, 305, 1'b0, 12, -1, 12'h0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
